serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 114 +++++++++++
 tb/tb_serial_subtractor.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: LSB-first full-subtractor over WIDTH cycles,
// with registered difference and final borrow presented alongside a one-cycle done pulse.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out_d,
    output logic             out_e
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] out_d_q, out_d_d;
    logic             out_e_q, out_e_d;
    logic             d_bit, e_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            out_d_q  <= '0;
            out_e_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            out_d_q  <= out_d_d;
            out_e_q  <= out_e_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        out_d_d  = out_d_q;
        out_e_d  = out_e_q;

        d_bit = a_sr_q[0] ^ b_sr_q[0] ^ borrow_q;
        e_bit = (~a_sr_q[0] & b_sr_q[0]) | (~a_sr_q[0] & borrow_q) | (b_sr_q[0] & borrow_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    a_sr_d   = in_a;
                    b_sr_d   = in_b;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                end
            end
            RUN: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                diff_d   = {d_bit, diff_q[WIDTH-1:1]};
                borrow_d = e_bit;
                cnt_d    = cnt_q + 1'b1;
                // Last bit: publish the fully shifted difference in the same edge.
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    out_d_d = {d_bit, diff_q[WIDTH-1:1]};
                    out_e_d = e_bit;
                end
            end
            DONE: begin
                if (start) begin
                    state_d  = RUN;
                    a_sr_d   = in_a;
                    b_sr_d   = in_b;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign out_d = out_d_q;
    assign out_e = out_e_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8): reset, results, corners,
// ignored mid-run start, mid-run reset and back-to-back operation.
module tb_serial_subtractor;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       busy;
    logic       done;
    logic [7:0] out_d;
    logic       out_e;

    int n_cmp;
    int n_fail;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in_a  (in_a),
        .in_b  (in_b),
        .busy  (busy),
        .done  (done),
        .out_d (out_d),
        .out_e (out_e)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts an operation and waits (bounded) for done; counts busy cycles seen.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         output int busy_cycles, output bit got_done);
        in_a = a;
        in_b = b;
        start = 1'b1;
        step();
        start = 1'b0;
        busy_cycles = 0;
        got_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
            step();
        end
    endtask

    task automatic test_reset();
        int bc;
        bit gd;
        rst = 1'b1;
        start = 1'b1;
        in_a = 8'hAA;
        in_b = 8'h11;
        step();
        step();
        start = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (out_d !== 8'h00) begin n_fail++; $display("FAIL reset_out_d: got %h want 00", out_d); end
        n_cmp++; if (out_e !== 1'b0) begin n_fail++; $display("FAIL reset_out_e: got %b want 0", out_e); end
        rst = 1'b0;
        do_op(8'h10, 8'h01, bc, gd);
        n_cmp++; if (gd !== 1'b1) begin n_fail++; $display("FAIL first_edge_done: got %b want 1", gd); end
        n_cmp++; if (bc != 8) begin n_fail++; $display("FAIL first_edge_busy: got %0d want 8", bc); end
        n_cmp++; if (out_d !== 8'h0F) begin n_fail++; $display("FAIL first_edge_d: got %h want 0f", out_d); end
        n_cmp++; if (out_e !== 1'b0) begin n_fail++; $display("FAIL first_edge_e: got %b want 0", out_e); end
        step();
    endtask

    task automatic test_basic();
        int bc;
        bit gd;
        do_op(8'h5A, 8'h23, bc, gd);
        n_cmp++; if (gd !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %b want 1", gd); end
        n_cmp++; if (bc != 8) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 8", bc); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done: got %b want 0", busy); end
        n_cmp++; if (out_d !== 8'h37) begin n_fail++; $display("FAIL basic_d: got %h want 37", out_d); end
        n_cmp++; if (out_e !== 1'b0) begin n_fail++; $display("FAIL basic_e: got %b want 0", out_e); end
        step();
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b want 0", done); end
        n_cmp++; if (out_d !== 8'h37) begin n_fail++; $display("FAIL basic_d_hold: got %h want 37", out_d); end
    endtask

    task automatic test_borrow();
        int bc;
        bit gd;
        do_op(8'h23, 8'h5A, bc, gd);
        n_cmp++; if (gd !== 1'b1) begin n_fail++; $display("FAIL borrow_done: got %b want 1", gd); end
        n_cmp++; if (out_d !== 8'hC9) begin n_fail++; $display("FAIL borrow_d: got %h want c9", out_d); end
        n_cmp++; if (out_e !== 1'b1) begin n_fail++; $display("FAIL borrow_e: got %b want 1", out_e); end
        step();
    endtask

    task automatic test_corners();
        logic [7:0] va [3] = '{8'h00, 8'hFF, 8'h80};
        logic [7:0] vb [3] = '{8'h01, 8'hFF, 8'h7F};
        logic [7:0] vd [3] = '{8'hFF, 8'h00, 8'h01};
        logic       ve [3] = '{1'b1, 1'b0, 1'b0};
        int bc;
        bit gd;
        for (int i = 0; i < 3; i++) begin
            do_op(va[i], vb[i], bc, gd);
            n_cmp++; if (gd !== 1'b1) begin n_fail++; $display("FAIL corner%0d_done: got %b want 1", i, gd); end
            n_cmp++; if (out_d !== vd[i]) begin n_fail++; $display("FAIL corner%0d_d: got %h want %h", i, out_d, vd[i]); end
            n_cmp++; if (out_e !== ve[i]) begin n_fail++; $display("FAIL corner%0d_e: got %b want %b", i, out_e, ve[i]); end
            step();
        end
    endtask

    task automatic test_start_ignored();
        int dones;
        logic [7:0] cap_d;
        logic cap_e;
        dones = 0;
        cap_d = 8'hXX;
        cap_e = 1'bx;
        in_a = 8'h5A;
        in_b = 8'h23;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        start = 1'b1;
        in_a = 8'h11;
        in_b = 8'h99;
        step();
        start = 1'b0;
        in_a = 8'hE7;
        in_b = 8'h3C;
        for (int i = 0; i < 16; i++) begin
            if (done) begin
                dones++;
                cap_d = out_d;
                cap_e = out_e;
            end
            step();
        end
        n_cmp++; if (dones != 1) begin n_fail++; $display("FAIL ignored_done_count: got %0d want 1", dones); end
        n_cmp++; if (cap_d !== 8'h37) begin n_fail++; $display("FAIL ignored_d: got %h want 37", cap_d); end
        n_cmp++; if (cap_e !== 1'b0) begin n_fail++; $display("FAIL ignored_e: got %b want 0", cap_e); end
    endtask

    task automatic test_reset_midrun();
        int dones;
        int bc;
        bit gd;
        in_a = 8'hC3;
        in_b = 8'h3C;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b want 0", done); end
        n_cmp++; if (out_d !== 8'h00) begin n_fail++; $display("FAIL midrst_out_d: got %h want 00", out_d); end
        n_cmp++; if (out_e !== 1'b0) begin n_fail++; $display("FAIL midrst_out_e: got %b want 0", out_e); end
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) dones++;
            step();
        end
        n_cmp++; if (dones != 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d want 0", dones); end
        do_op(8'hC3, 8'h3C, bc, gd);
        n_cmp++; if (gd !== 1'b1) begin n_fail++; $display("FAIL midrst_fresh_done: got %b want 1", gd); end
        n_cmp++; if (out_d !== 8'h87) begin n_fail++; $display("FAIL midrst_fresh_d: got %h want 87", out_d); end
        n_cmp++; if (out_e !== 1'b0) begin n_fail++; $display("FAIL midrst_fresh_e: got %b want 0", out_e); end
        step();
    endtask

    task automatic test_back_to_back();
        int dones;
        int last_c;
        in_a = 8'h40;
        in_b = 8'h41;
        start = 1'b1;
        step();
        dones = 0;
        last_c = 0;
        for (int c = 1; c <= 30; c++) begin
            n_cmp++; if (busy && done) begin n_fail++; $display("FAIL b2b_exclusive c%0d: busy=%b done=%b want not both", c, busy, done); end
            if (done) begin
                dones++;
                n_cmp++; if (c - last_c != 9) begin n_fail++; $display("FAIL b2b_period: got %0d want 9", c - last_c); end
                n_cmp++; if (out_d !== 8'hFF) begin n_fail++; $display("FAIL b2b_d: got %h want ff", out_d); end
                n_cmp++; if (out_e !== 1'b1) begin n_fail++; $display("FAIL b2b_e: got %b want 1", out_e); end
                last_c = c;
            end
            step();
            if (done === 1'b0 && last_c == c - 1 && last_c != 0) begin
                n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart_busy: got %b want 1", busy); end
            end
        end
        start = 1'b0;
        n_cmp++; if (dones != 3) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 3", dones); end
        step();
        step();
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst = 1'b1;
        start = 1'b0;
        in_a = 8'h00;
        in_b = 8'h00;
        test_reset();
        test_basic();
        test_borrow();
        test_corners();
        test_start_ignored();
        test_reset_midrun();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
